// File: rtl/matriz_pkg.sv
// Shared types and defaults for the matrix add/subtract sequencer.
// Holds the FSM state encoding, op encodings and default storage geometry.
package matriz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } estado_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int TAMANHO_DEF = 5;
    localparam int WIDTH_DEF   = 8;

endpackage

// File: rtl/controle_matriz_if.sv
// Command, memory-port and status bundle between host/memories and the sequencer.
// master = sequencer view, slave = host and memory view.
interface controle_matriz_if
    import matriz_pkg::*;
#(
    parameter int TAMANHO = TAMANHO_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int AW      = $clog2(TAMANHO * TAMANHO)
);
    logic             start;
    logic             op;
    logic [3:0]       size;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_a_data;
    logic [WIDTH-1:0] rd_b_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             ovf;

    modport master (
        input  start, op, size, rd_a_data, rd_b_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err, ovf
    );

    modport slave (
        output start, op, size, rd_a_data, rd_b_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err, ovf
    );
endinterface

// File: rtl/contador_indice.sv
// Row-major (i, j) walker over an n x n sub-grid; flat address is i*TAMANHO + j.
// Zero latency from state to address/last; no backpressure, advances only on en.
module contador_indice
    import matriz_pkg::*;
#(
    parameter int TAMANHO = TAMANHO_DEF,
    localparam int AW     = $clog2(TAMANHO * TAMANHO)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [3:0]    n_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    localparam logic [AW-1:0] STRIDE = AW'(TAMANHO);

    logic [3:0] i_q;
    logic [3:0] j_q;
    logic [3:0] lim;

    assign lim    = n_i - 4'd1;
    assign last_o = (i_q == lim) && (j_q == lim);
    assign addr_o = AW'(i_q) * STRIDE + AW'(j_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= 4'd0;
            j_q <= 4'd0;
        end else if (load_i) begin
            i_q <= 4'd0;
            j_q <= 4'd0;
        end else if (en_i) begin
            if (j_q == lim) begin
                j_q <= 4'd0;
                i_q <= i_q + 4'd1;
            end else begin
                j_q <= j_q + 4'd1;
            end
        end
    end
endmodule

// File: rtl/controle_matriz.sv
// Sequencer for C = A +/- B over an n x n sub-grid: one read per cycle, write two cycles later.
// Latency n*n+3 cycles start-to-done; no backpressure, start is ignored unless IDLE.
module controle_matriz
    import matriz_pkg::*;
#(
    parameter int TAMANHO = TAMANHO_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    controle_matriz_if.master  bus
);
    localparam int AW            = $clog2(TAMANHO * TAMANHO);
    localparam logic [3:0] N_MAX = 4'(TAMANHO);

    estado_t          estado_q;
    logic             op_q;
    logic [3:0]       n_q;
    logic             drain_q;
    logic             rd_en_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             ovf_q;
    logic             s1_vld_q;
    logic [AW-1:0]    s1_addr_q;
    logic             wr_en_q;
    logic [AW-1:0]    wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;

    logic             size_ok;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_last;
    logic [AW-1:0]    cnt_addr;
    logic [AW-1:0]    rd_addr_w;
    logic [WIDTH:0]   res_d;

    assign size_ok  = (bus.size >= 4'd2) && (bus.size <= N_MAX);
    assign cnt_load = (estado_q == IDLE) && bus.start && size_ok;
    assign cnt_en   = (estado_q == RUN) && !cnt_last;

    contador_indice #(.TAMANHO(TAMANHO)) u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .n_i    (n_q),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    // Address bus is parked at zero whenever no read is being issued.
    assign rd_addr_w = rd_en_q ? cnt_addr : '0;

    // Bit WIDTH is the carry for add and the borrow for subtract.
    always_comb begin
        res_d = '0;
        if (op_q == OP_SUB) res_d = {1'b0, bus.rd_a_data} - {1'b0, bus.rd_b_data};
        else                res_d = {1'b0, bus.rd_a_data} + {1'b0, bus.rd_b_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            op_q     <= OP_ADD;
            n_q      <= 4'd0;
            drain_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: if (bus.start) begin
                    op_q  <= bus.op;
                    n_q   <= bus.size;
                    ovf_q <= 1'b0;
                    if (size_ok) begin
                        estado_q <= RUN;
                        rd_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                    end else begin
                        estado_q <= DONE;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end
                end
                RUN: if (cnt_last) begin
                    estado_q <= DRAIN;
                    rd_en_q  <= 1'b0;
                    drain_q  <= 1'b0;
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        estado_q <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    estado_q <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
            // Pipeline is empty in IDLE, so this never races the clear above.
            if (s1_vld_q && res_d[WIDTH]) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            s1_vld_q  <= rd_en_q;
            s1_addr_q <= rd_addr_w;
            wr_en_q   <= s1_vld_q;
            if (s1_vld_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= res_d[WIDTH-1:0];
            end
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_w;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: doc/controle_matriz.md
# controle_matriz

Sequencer for the element-wise 8-bit matrix add/subtract datapath. On a start request it walks an n×n sub-grid of the TAMANHO×TAMANHO operand storage in row-major order, reads A[i][j] and B[i][j], computes C[i][j] = A ± B (mod 2^WIDTH), and writes the result back to C storage. It sits between the host-side command logic and the three matrix memories, replacing the free-running combinational loop with a cycle-accurate, restartable schedule.

## Interface
- TAMANHO, 5, storage dimension (row stride); legal 2..15
- WIDTH, 8, element width in bits
- AW, $clog2(TAMANHO*TAMANHO), flat address width (5 for defaults)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  command request; sampled only in IDLE
- op  in  1  0 = add, 1 = subtract; latched with start
- size  in  4  active dimension n; latched with start; legal 2..TAMANHO
- rd_en  out  1  read strobe to A and B memories
- rd_addr  out  AW  flat read address i*TAMANHO + j
- rd_a_data  in  WIDTH  A element, valid exactly 1 cycle after rd_en
- rd_b_data  in  WIDTH  B element, valid exactly 1 cycle after rd_en
- wr_en  out  1  write strobe to C memory
- wr_addr  out  AW  flat write address
- wr_data  out  WIDTH  result element
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  illegal size on last command; held until next accepted start
- ovf  out  1  sticky: any carry (add) or borrow (sub) during current command

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches op and size, clears err and ovf. Legal size → RUN with i=j=0; illegal (0, 1, >TAMANHO) → DONE with err=1, no reads or writes.
- RUN: rd_en=1 every cycle, rd_addr=i*TAMANHO+j; j increments, wraps n-1→0 with i++. After issuing (n-1, n-1) → DRAIN.
- DRAIN: rd_en=0; stays 2 cycles to flush read-return and write stages → DONE.
- DONE: done=1 for one cycle → IDLE.
- Pipeline: stage 1 registers issued address; stage 2 (data-return cycle) computes WIDTH+1-bit sum/difference and registers low WIDTH bits into wr_data, address into wr_addr, wr_en=1. Bit WIDTH of the result ORs into ovf.
- Arithmetic: results wrap modulo 2^WIDTH (0x04−0x05 = 0xFF, ovf=1).
- start while busy or in DONE: ignored, no effect on latched op/size.
- Cells outside the n×n sub-grid are never read or written.

## Timing
- Cycle 0 = cycle start is sampled high in IDLE.
- rd_en high cycles 1..n²; read data returns cycles 2..n²+1; wr_en high cycles 3..n²+2, one write per cycle, no gaps.
- done pulses cycle n²+3; busy high cycles 1..n²+2, low on done cycle.
- Illegal size: done and err both high on cycle 1; busy never asserts.
- Back-to-back: earliest next start sampled on cycle n²+4 (first IDLE cycle).
- Reset (any cycle, including mid-RUN/DRAIN): all outputs 0 immediately (rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err, ovf = 0), state IDLE, counters 0; partial writes already issued stand, none further.

## Structure
- Package matriz_pkg: state enum (IDLE, RUN, DRAIN, DONE), op encodings OP_ADD=0 / OP_SUB=1, default TAMANHO and WIDTH constants.
- One sub-module: contador_indice — row/column counter with load, enable, bound n, flat address output and last-element flag.
- FSM, two-stage pipeline and flags stay in controle_matriz.

## Test plan
- size=5, op=sub, all A=B=0x04 → 25 writes of 0x00 to addresses 0..24 in order, cycles 3..27; done cycle 28; ovf=0.
- size=5, op=add, A=B=0x80 at every cell → all wr_data 0x00, ovf=1 after first write, held to done.
- size=2, op=sub, A=0x04, B=0x05 → writes 0xFF to addresses 0,1,5,6 on cycles 3..6; done cycle 7; ovf=1.
- size=6 (and size=1) → done and err on cycle 1, no rd_en/wr_en ever; next legal start clears err.
- start held high throughout a size=3 run → exactly one command executes (9 writes), second accepted only on first IDLE cycle after done.
- rst_n low on cycle 10 of a size=5 run → all outputs 0 same cycle, no wr_en after, next start runs full schedule from address 0.
